// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/bubble/flush controller with a debug halt/step FSM,
// saturating performance counters and a stall watchdog.
module pipe_ctrl #(
  parameter int STAGES  = 6,
  parameter int NREQ    = 3,
  parameter int SW      = 3,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic [NREQ*SW-1:0] req_stage,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  input  logic              halt_req,
  input  logic              step,
  input  logic              resume,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              stall_timeout
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]   TOP_STAGE = SW'(STAGES - 1);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

  state_t            state;
  state_t            next_state;
  logic [SW-1:0]     clamp_idx;
  logic [SW-1:0]     max_stage;
  logic              any_req;
  logic [STAGES-1:0] merge_stall;
  logic [STAGES-1:0] merge_bubble;
  logic              req_stall_cycle;
  logic [WD_W-1:0]   wd_cnt;

  // Find the deepest stage any active source wants frozen; out-of-range indices clamp to the last stage
  always_comb begin
    any_req   = |stall_req;
    max_stage = '0;
    clamp_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      clamp_idx = req_stage[i*SW +: SW];
      if (clamp_idx > TOP_STAGE) begin
        clamp_idx = TOP_STAGE;
      end
      if (stall_req[i] && (clamp_idx > max_stage)) begin
        max_stage = clamp_idx;
      end
    end
  end

  // Everything up to the deepest stalled stage holds; the stage just past it receives a bubble
  always_comb begin
    merge_stall  = '0;
    merge_bubble = '0;
    for (int k = 0; k < STAGES; k++) begin
      merge_stall[k]  = (k <= int'(max_stage));
      merge_bubble[k] = (k == int'(max_stage) + 1);
    end
  end

  // Final pipeline controls: reset forces idle, HALT freezes everything, otherwise flush beats stalls
  always_comb begin
    stall  = '0;
    bubble = '0;
    flush  = 1'b0;
    new_pc = '0;
    if (!rst) begin
      if (state == HALT) begin
        stall = '1;
      end else if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else if (any_req) begin
        stall  = merge_stall;
        bubble = merge_bubble;
      end
    end
  end

  // A cycle counts as request-caused stall only when not halted, some source asks, and no flush wins
  always_comb begin
    req_stall_cycle = (state != HALT) && any_req && !flush_req;
  end

  // Debug FSM transitions: resume beats step in HALT, STEP lasts exactly one cycle
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (halt_req) begin
          next_state = HALT;
        end
      end
      HALT: begin
        if (resume) begin
          next_state = RUN;
        end else if (step) begin
          next_state = STEP;
        end
      end
      STEP: begin
        next_state = HALT;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Debug FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  assign halted = (state == HALT);

  // Saturating performance counters; a clear request wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (req_stall_cycle && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Watchdog: run length of back-to-back request stalls, frozen while halted, sticky trip flag
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (state != HALT) begin
      if (req_stall_cycle) begin
        if (wd_cnt != WD_LIMIT) begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
        if (wd_cnt >= WD_LAST) begin
          stall_timeout <= 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test-plan sequences plus randomized traffic against a
// behavioural model of pipe_ctrl (STAGES=6, NREQ=3, SW=3, CNT_W=8, TIMEOUT=8).
module tb_pipe_ctrl;

  localparam int STAGES  = 6;
  localparam int NREQ    = 3;
  localparam int SW      = 3;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = 255;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   stall_req;
  logic [NREQ*SW-1:0] req_stage;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic              halt_req;
  logic              step;
  logic              resume;
  logic              cnt_clr;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic              flush;
  logic [31:0]       new_pc;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              stall_timeout;

  int total;
  int bad;

  // Model of the debug state: halted, or taking the single stepped cycle
  bit mHalt;
  bit mStep;
  int mStallCnt;
  int mFlushCnt;
  int mRun;
  bit mTimeout;

  pipe_ctrl #(
    .STAGES(STAGES), .NREQ(NREQ), .SW(SW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .req_stage(req_stage),
    .flush_req(flush_req), .flush_pc(flush_pc), .halt_req(halt_req),
    .step(step), .resume(resume), .cnt_clr(cnt_clr), .stall(stall),
    .bubble(bubble), .flush(flush), .new_pc(new_pc), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
  );

  // Free-running core clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model mid-cycle, then advance the model at the edge
  task automatic applyStimulus(input logic r, input logic [2:0] sr, input logic [8:0] rs,
                               input logic fr, input logic [31:0] fp, input logic hr,
                               input logic st, input logic rsm, input logic cc);
    logic [5:0]  eStall;
    logic [5:0]  eBubble;
    logic        eFlush;
    logic [31:0] ePc;
    int          deepest;
    int          s;
    bit          reqCycle;
    rst = r; stall_req = sr; req_stage = rs; flush_req = fr; flush_pc = fp;
    halt_req = hr; step = st; resume = rsm; cnt_clr = cc;

    deepest = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (sr[i]) begin
        s = int'(rs[i*SW +: SW]);
        if (s > STAGES - 1) s = STAGES - 1;
        if (s > deepest) deepest = s;
      end
    end
    eStall = '0; eBubble = '0; eFlush = 1'b0; ePc = '0;
    if (!r) begin
      if (mHalt) begin
        eStall = 6'h3f;
      end else if (fr) begin
        eFlush = 1'b1;
        ePc    = fp;
      end else if (deepest >= 0) begin
        eStall  = 6'((1 << (deepest + 1)) - 1);
        eBubble = (deepest < STAGES - 1) ? 6'(1 << (deepest + 1)) : 6'd0;
      end
    end

    @(negedge clk);
    checkOutput("stall", 64'(stall), 64'(eStall));
    checkOutput("bubble", 64'(bubble), 64'(eBubble));
    checkOutput("flush", 64'(flush), 64'(eFlush));
    checkOutput("new_pc", 64'(new_pc), 64'(ePc));
    checkOutput("halted", 64'(halted), 64'(mHalt));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(mStallCnt));
    checkOutput("flush_cnt", 64'(flush_cnt), 64'(mFlushCnt));
    checkOutput("stall_timeout", 64'(stall_timeout), 64'(mTimeout));

    @(posedge clk);
    if (r) begin
      mHalt = 0; mStep = 0; mStallCnt = 0; mFlushCnt = 0; mRun = 0; mTimeout = 0;
    end else begin
      reqCycle = !mHalt && (deepest >= 0) && !eFlush;
      if (cc) begin
        mStallCnt = 0; mFlushCnt = 0; mRun = 0; mTimeout = 0;
      end else begin
        if (reqCycle && mStallCnt < CNT_MAX) mStallCnt++;
        if (eFlush && mFlushCnt < CNT_MAX) mFlushCnt++;
        if (!mHalt) begin
          if (reqCycle) begin
            if (mRun < TIMEOUT) mRun++;
            if (mRun >= TIMEOUT) mTimeout = 1;
          end else begin
            mRun = 0;
          end
        end
      end
      if (mHalt) begin
        if (rsm) mHalt = 0;
        else if (st) begin mHalt = 0; mStep = 1; end
      end else if (mStep) begin
        mStep = 0; mHalt = 1;
      end else if (hr) begin
        mHalt = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 0, 0, 0, 0);
  endtask

  task automatic holdStall(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'b001, 9'd2, 0, 32'd0, 0, 0, 0, 0);
  endtask

  // Directed test-plan sequences followed by randomized traffic
  initial begin
    total = 0; bad = 0;
    mHalt = 0; mStep = 0; mStallCnt = 0; mFlushCnt = 0; mRun = 0; mTimeout = 0;
    rst = 1; stall_req = '0; req_stage = '0; flush_req = 0; flush_pc = '0;
    halt_req = 0; step = 0; resume = 0; cnt_clr = 0;
    @(posedge clk); #1;

    // Reset gates requests and flushes
    applyStimulus(1, 3'b111, 9'o555, 1, 32'h1234, 0, 0, 0, 0);
    // Single source at stage 2
    applyStimulus(0, 3'b001, 9'o002, 0, 32'd0, 0, 0, 0, 0);
    idle(1);
    // Sources at stages 2 and 4, then stage 5 alone
    applyStimulus(0, 3'b011, 9'o042, 0, 32'd0, 0, 0, 0, 0);
    applyStimulus(0, 3'b100, 9'o500, 0, 32'd0, 0, 0, 0, 0);
    // Clamped out-of-range index and mixed indices
    applyStimulus(0, 3'b010, 9'o070, 0, 32'd0, 0, 0, 0, 0);
    applyStimulus(0, 3'b101, 9'o103, 0, 32'd0, 0, 0, 0, 0);
    // Flush dominates active stall requests
    applyStimulus(0, 3'b111, 9'o123, 1, 32'hBFC0_0380, 0, 0, 0, 0);
    idle(1);
    // Halt, single step, resume
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 1, 0, 0, 0);
    applyStimulus(0, 3'b001, 9'd3, 1, 32'h40, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 0, 1, 0, 0);
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 1, 1, 0, 0);
    idle(2);
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 0, 1, 1, 0);
    idle(2);
    // Halt request coinciding with a flush
    applyStimulus(0, 3'b001, 9'd1, 1, 32'h8000_0180, 1, 0, 0, 0);
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 0, 0, 1, 0);
    // Watchdog trips after TIMEOUT consecutive request stalls
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 0, 0, 0, 1);
    holdStall(TIMEOUT);
    idle(2);
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 0, 0, 0, 1);
    // A one-cycle drop restarts the run so there is no trip
    holdStall(4);
    idle(1);
    holdStall(4);
    idle(1);
    // Halt freezes the run length without clearing it
    holdStall(5);
    applyStimulus(0, 3'b001, 9'd2, 0, 32'd0, 1, 0, 0, 0);
    holdStall(3);
    applyStimulus(0, 3'b001, 9'd2, 0, 32'd0, 0, 0, 1, 0);
    holdStall(3);
    applyStimulus(0, 3'b001, 9'd2, 0, 32'd0, 0, 0, 0, 1);
    // Reset mid-HALT with nonzero counters
    holdStall(3);
    applyStimulus(0, 3'b000, 9'd0, 0, 32'd0, 1, 0, 0, 0);
    applyStimulus(1, 3'b010, 9'o030, 0, 32'd0, 0, 0, 0, 0);
    applyStimulus(0, 3'b010, 9'o030, 0, 32'd0, 0, 0, 0, 0);
    // Counter saturation
    holdStall(CNT_MAX + 5);
    for (int i = 0; i < CNT_MAX + 5; i++) applyStimulus(0, 3'b000, 9'd0, 1, 32'(i), 0, 0, 0, 0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    3'($urandom_range(0, 7)),
                    9'($urandom),
                    ($urandom_range(0, 7) == 0),
                    $urandom,
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
